// File: rtl/trace_store_fifo.sv
// ---------------------------------------------------------------------------
// trace_store_fifo
//
// First-word-fall-through FIFO between the trace deserializer and its
// downstream consumer. The upstream side uses a store/permission handshake
// and the downstream side uses a valid/ready handshake. A store attempt that
// arrives while permission is withheld is dropped and flagged on a sticky
// overrun output.
//
// Parameters
//   WIDTH : trace word width (defaults to the trace bus width TRB_WIDTH)
//   DEPTH : number of stored words, power of two, >= 2
//
// Ports
//   CLK_I        in   clock, rising edge
//   RST_I        in   asynchronous active-high reset
//   FLUSH_I      in   synchronous clear of contents and overrun flag
//   STORE_I      in   write request from the deserializer
//   DATA_I       in   word to store
//   STORE_PERM_O out  write permission (not full and not in reset)
//   DATA_VALID_O out  DATA_O holds the oldest stored word
//   DATA_READY_I in   consumer accepts DATA_O
//   DATA_O       out  oldest stored word (fall-through)
//   FILL_O       out  current word count (only with STB_FIFO_FILL_LEVEL_EN)
//   OVERRUN_O    out  sticky: store requested while permission was low
//
// Build option
//   STB_FIFO_FILL_LEVEL_EN : adds the FILL_O port.
// ---------------------------------------------------------------------------
`ifndef TRB_WIDTH
`define TRB_WIDTH 32
`endif

module trace_store_fifo #(
    parameter int WIDTH = `TRB_WIDTH,
    parameter int DEPTH = 16
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     FLUSH_I,
    input  logic                     STORE_I,
    input  logic [WIDTH-1:0]         DATA_I,
    output logic                     STORE_PERM_O,
    output logic                     DATA_VALID_O,
    input  logic                     DATA_READY_I,
    output logic [WIDTH-1:0]         DATA_O,
`ifdef STB_FIFO_FILL_LEVEL_EN
    output logic [$clog2(DEPTH):0]   FILL_O,
`endif
    output logic                     OVERRUN_O
);

    localparam int PTR_W = $clog2(DEPTH);
    // Count runs 0..DEPTH, so "full" is the single value DEPTH.
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]   count_reg, count_next;
    logic             overrun_reg, overrun_next;
    logic             wr_en, rd_en;

    // Storage is never reset; DATA_O is only qualified by DATA_VALID_O, which
    // is high only for locations that have been written since reset.
    logic [WIDTH-1:0] mem [DEPTH];

    // Permission is gated by RST_I directly so it drops the instant reset
    // asserts, not only once the count register has cleared.
    assign STORE_PERM_O = (count_reg != FULL_CNT) && !RST_I;
    assign DATA_VALID_O = (count_reg != '0);
    assign DATA_O       = mem[rd_ptr_reg];
    assign OVERRUN_O    = overrun_reg;
`ifdef STB_FIFO_FILL_LEVEL_EN
    assign FILL_O       = count_reg;
`endif

    // Flush wins over both handshakes, so neither side advances that cycle.
    assign wr_en = STORE_I && STORE_PERM_O && !FLUSH_I;
    assign rd_en = DATA_VALID_O && DATA_READY_I && !FLUSH_I;

    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        overrun_next = overrun_reg;
        if (FLUSH_I) begin
            wr_ptr_next  = '0;
            rd_ptr_next  = '0;
            count_next   = '0;
            overrun_next = 1'b0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so +1 wraps DEPTH-1 -> 0.
            if (wr_en) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
            if (STORE_I && !STORE_PERM_O) begin
                overrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            overrun_reg <= overrun_next;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= DATA_I;
        end
    end

endmodule

// File: tb/tb_trace_store_fifo.sv
// ---------------------------------------------------------------------------
// tb_trace_store_fifo
//
// Self-checking bench for trace_store_fifo with WIDTH=8, DEPTH=4. A queue
// holds the words the FIFO should contain; stores push to it, pops compare
// DATA_O against its head. Flags and handshake outputs are checked against
// the same reference every cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_trace_store_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             CLK_I = 1'b0;
    logic             RST_I;
    logic             FLUSH_I;
    logic             STORE_I;
    logic [WIDTH-1:0] DATA_I;
    logic             STORE_PERM_O;
    logic             DATA_VALID_O;
    logic             DATA_READY_I;
    logic [WIDTH-1:0] DATA_O;
    logic             OVERRUN_O;
`ifdef STB_FIFO_FILL_LEVEL_EN
    logic [$clog2(DEPTH):0] FILL_O;
`endif

    trace_store_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .FLUSH_I     (FLUSH_I),
        .STORE_I     (STORE_I),
        .DATA_I      (DATA_I),
        .STORE_PERM_O(STORE_PERM_O),
        .DATA_VALID_O(DATA_VALID_O),
        .DATA_READY_I(DATA_READY_I),
        .DATA_O      (DATA_O),
`ifdef STB_FIFO_FILL_LEVEL_EN
        .FILL_O      (FILL_O),
`endif
        .OVERRUN_O   (OVERRUN_O)
    );

    always #5 CLK_I = ~CLK_I;

    int total = 0;
    int bad   = 0;
    bit verbose = 1'b1;

    logic [WIDTH-1:0] sb_q[$];
    logic             ovr_m = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: check outputs against the reference on the falling
    // edge, advance the reference by the handshakes the inputs imply, then
    // step past the rising edge.
    task automatic cycle();
        bit wr, rd, full;
        logic [WIDTH-1:0] exp_word;
        @(negedge CLK_I);
        full = (sb_q.size() == DEPTH);
        check_val("valid", 32'(DATA_VALID_O), 32'(sb_q.size() != 0));
        check_val("perm", 32'(STORE_PERM_O), 32'(!full));
        check_val("overrun", 32'(OVERRUN_O), 32'(ovr_m));
`ifdef STB_FIFO_FILL_LEVEL_EN
        check_val("fill", 32'(FILL_O), 32'(sb_q.size()));
`endif
        if (FLUSH_I) begin
            sb_q.delete();
            ovr_m = 1'b0;
            if (verbose) $display("flush");
        end else begin
            wr = STORE_I && !full;
            rd = DATA_READY_I && (sb_q.size() != 0);
            if (STORE_I && full) ovr_m = 1'b1;
            if (rd) begin
                exp_word = sb_q.pop_front();
                check_val("data", 32'(DATA_O), 32'(exp_word));
                if (verbose) $display("read  data=%h expected=%h", DATA_O, exp_word);
            end
            if (wr) begin
                sb_q.push_back(DATA_I);
                if (verbose) $display("write data=%h", DATA_I);
            end
        end
        @(posedge CLK_I);
        #1;
    endtask

    task automatic drive(input logic st, input logic [WIDTH-1:0] d,
                         input logic rdy, input logic fl);
        STORE_I      = st;
        DATA_I       = d;
        DATA_READY_I = rdy;
        FLUSH_I      = fl;
        cycle();
    endtask

    initial begin
        RST_I = 1'b1; FLUSH_I = 1'b0; STORE_I = 1'b0;
        DATA_I = '0; DATA_READY_I = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK_I);
        #1;
        check_val("rst_valid", 32'(DATA_VALID_O), 32'd0);
        check_val("rst_perm", 32'(STORE_PERM_O), 32'd0);
        check_val("rst_overrun", 32'(OVERRUN_O), 32'd0);
        RST_I = 1'b0;

        // Fill with four words, consumer stalled; permission right after reset
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        drive(1'b1, 8'h44, 1'b0, 1'b0);
        // Store while full: dropped, overrun sets and sticks
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Streaming at count=2 across pointer wrap
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b1, 8'hF1, 1'b0, 1'b0);
        drive(1'b1, 8'hF2, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("stream_cnt", 32'(sb_q.size()), 32'd2);

        // Flush at count=3 beats a simultaneous store and read, clears overrun
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 8'hEE, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset between edges at count=2
        drive(1'b1, 8'hC1, 1'b0, 1'b0);
        drive(1'b1, 8'hC2, 1'b0, 1'b0);
        STORE_I = 1'b0;
        #2;
        RST_I = 1'b1;
        #1;
        check_val("arst_valid", 32'(DATA_VALID_O), 32'd0);
        check_val("arst_perm", 32'(STORE_PERM_O), 32'd0);
        sb_q.delete();
        ovr_m = 1'b0;
        @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        drive(1'b1, 8'h7E, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic
        verbose = 1'b0;
        for (int i = 0; i < 1000; i++)
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        $display("random traffic: 1000 cycles, %0d words left in queue", sb_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_store_fifo.md
TRACE_STORE_FIFO -- requirements
Module: trace_store_fifo

Interface
REQ-001 Parameter WIDTH, default TRB_WIDTH: trace word width in bits; SHALL equal the deserializer DATA_O width.
REQ-002 Parameter DEPTH, default 16: number of stored words; SHALL be a power of two, minimum 2.
REQ-003 CLK_I  in  1: single clock; all state changes on its rising edge.
REQ-004 RST_I  in  1: asynchronous, active-high reset.
REQ-005 FLUSH_I  in  1: synchronous clear of stored contents.
REQ-006 STORE_I  in  1: write request from the upstream deserializer.
REQ-007 DATA_I  in  WIDTH: trace word to store.
REQ-008 STORE_PERM_O  out  1: write permission to the upstream deserializer.
REQ-009 DATA_VALID_O  out  1: DATA_O holds the oldest stored word.
REQ-010 DATA_READY_I  in  1: downstream consumer accepts DATA_O.
REQ-011 DATA_O  out  WIDTH: oldest stored word.
REQ-012 OVERRUN_O  out  1: sticky flag, set when STORE_I is high while STORE_PERM_O is low.

Function
REQ-013 State: write pointer, read pointer, each log2(DEPTH) bits, wrapping DEPTH-1 -> 0; count of $clog2(DEPTH)+1 bits, range 0..DEPTH.
REQ-014 STORE_PERM_O SHALL be high exactly when count < DEPTH and RST_I is low; it is combinational from registered count.
REQ-015 Write: STORE_I && STORE_PERM_O at an edge stores DATA_I at the write pointer and increments the write pointer.
REQ-016 Read: DATA_VALID_O && DATA_READY_I at an edge pops the oldest word and increments the read pointer.
REQ-017 DATA_VALID_O SHALL be high exactly when count > 0; DATA_O SHALL show memory[read pointer], first-word fall-through.
REQ-018 Latency: a word written at edge n SHALL be visible on DATA_O with DATA_VALID_O high in the cycle after edge n, if the FIFO was empty.
REQ-019 Simultaneous write and read with 0 < count < DEPTH: both occur and count is unchanged.
REQ-020 Empty: there is no write-through; a read handshake is impossible because DATA_VALID_O is low.
REQ-021 Full: STORE_PERM_O is low, so no write occurs even if a read pops in the same cycle; permission returns the cycle after the pop.
REQ-022 STORE_I with STORE_PERM_O low SHALL be ignored (no write, pointers unchanged) and SHALL set OVERRUN_O.
REQ-023 FLUSH_I high at an edge zeroes both pointers and count, and clears OVERRUN_O. It has priority over a simultaneous write and read, neither of which takes effect.
REQ-024 DATA_O SHALL never carry X while DATA_VALID_O is high. Its value while DATA_VALID_O is low is don't-care.

Reset
REQ-025 While RST_I is high: pointers = 0, count = 0, OVERRUN_O = 0, DATA_VALID_O = 0, STORE_PERM_O = 0; memory contents are not cleared.
REQ-026 Reset asserted mid-operation SHALL discard all stored words immediately, without waiting for a clock edge.
REQ-027 After reset deassertion, STORE_PERM_O SHALL be high in the first cycle.

Configuration
REQ-028 Macro STB_FIFO_FILL_LEVEL_EN: when defined, add output port FILL_O ($clog2(DEPTH)+1 bits) equal to the registered count, 0 in reset. When undefined, the port and its logic are absent and all other behaviour is identical.

Verification (WIDTH=8, DEPTH=4)
REQ-029 Reset released; STORE_I high for 4 cycles with DATA_I 0x11, 0x22, 0x33, 0x44; DATA_READY_I=0 -> STORE_PERM_O low after 4th edge, DATA_O=0x11 with DATA_VALID_O high from the cycle after the 1st edge, OVERRUN_O=0.
REQ-030 Full FIFO from REQ-029; STORE_I=1, DATA_I=0x55 for one cycle -> 0x55 not stored, OVERRUN_O=1 and stays 1; then 4 reads return 0x11, 0x22, 0x33, 0x44, DATA_VALID_O low afterwards.
REQ-031 Count=2; STORE_I and DATA_READY_I both high for 10 cycles with DATA_I incrementing from 0xA0 -> count stays 2, output order preserved across pointer wrap, no loss or duplication.
REQ-032 Count=3; FLUSH_I=1 together with STORE_I=1 and DATA_READY_I=1 -> next cycle count=0, DATA_VALID_O=0, STORE_PERM_O=1, OVERRUN_O=0.
REQ-033 Count=2; RST_I pulsed high between clock edges -> DATA_VALID_O and STORE_PERM_O drop immediately; after release, a write of 0x7E is the first word read.
REQ-034 Random STORE_I/DATA_READY_I for 1000 cycles with scoreboard -> every read equals the next written word in order, and STORE_PERM_O is never high at count=4 (assertion).
